// File: rtl/alu_seq.sv
// alu_seq: multi-cycle ALU with valid/ready handshakes, iterative shifts and shift-add multiply
module alu_seq #(
  parameter int WIDTH = 16,
  parameter int SHW = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] res,
  output logic [3:0]       szcv
);
  localparam logic [3:0] OP_ADD = 4'b0000, OP_SUB = 4'b0001, OP_AND = 4'b0010, OP_OR = 4'b0011,
                         OP_XOR = 4'b0100, OP_CMP = 4'b0101, OP_MOV = 4'b0110, OP_SLL = 4'b1000,
                         OP_ROL = 4'b1001, OP_SRL = 4'b1010, OP_SRA = 4'b1011, OP_MUL = 4'b1100;
  localparam int M = WIDTH - 1;
  localparam logic [SHW:0] CNT_MUL = (SHW+1)'(WIDTH);
  localparam logic [SHW:0] CNT_ONE = (SHW+1)'(1);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t state, state_n;
  logic [3:0] op_r;
  logic [WIDTH-1:0] w, w_n, hi, hi_n, lo, lo_n, r1, r_b;
  logic [WIDTH:0] sum, dif, madd;
  logic [SHW:0] cnt;
  logic [SHW-1:0] n;
  logic c_r, c_n, c1, v1, c_b, is_shift, multi, last;
  assign n = b[SHW-1:0];
  assign is_shift = op[3:2] == 2'b10;
  assign multi = op == OP_MUL || (is_shift && n != '0);
  assign last = cnt == CNT_ONE;
  assign in_ready = state == IDLE;
  assign out_valid = state == DONE;
  assign sum = {1'b0, a} + {1'b0, b};
  assign dif = {1'b0, a} - {1'b0, b};
  assign madd = {1'b0, hi} + (lo[0] ? {1'b0, w} : '0);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_n;
  always_comb begin
    state_n = state;
    case (state)
      IDLE: state_n = in_valid ? (multi ? BUSY : DONE) : IDLE;
      BUSY: state_n = last ? DONE : BUSY;
      DONE: state_n = out_ready ? IDLE : DONE;
      default: state_n = IDLE;
    endcase
  end
  // single-cycle result, also used for zero-count shifts (res = a, C = 0)
  always_comb begin
    {c1, r1} = '0;
    v1 = 1'b0;
    case (op)
      OP_ADD: begin
        {c1, r1} = sum;
        v1 = a[M] == b[M] && sum[M] != a[M];
      end
      OP_SUB, OP_CMP: begin
        {c1, r1} = dif;
        v1 = a[M] != b[M] && dif[M] != a[M];
      end
      OP_AND: r1 = a & b;
      OP_OR:  r1 = a | b;
      OP_XOR: r1 = a ^ b;
      OP_MOV: r1 = b;
      OP_SLL, OP_ROL, OP_SRL, OP_SRA: r1 = a;
      default: r1 = '0;
    endcase
  end
  // one iteration: a single-bit shift of w, or one shift-add step on {hi,lo}
  always_comb begin
    w_n = w;
    c_n = c_r;
    hi_n = hi;
    lo_n = lo;
    case (op_r)
      OP_SLL: {c_n, w_n} = {w, 1'b0};
      OP_ROL: w_n = {w[M-1:0], w[M]};
      OP_SRL: {w_n, c_n} = {1'b0, w};
      OP_SRA: {w_n, c_n} = {w[M], w};
      OP_MUL: {hi_n, lo_n} = {madd, lo[M:1]};
      default: ;
    endcase
    r_b = op_r == OP_MUL ? lo_n : w_n;
    c_b = op_r == OP_MUL ? |hi_n : c_n;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      op_r <= '0;
      w <= '0;
      hi <= '0;
      lo <= '0;
      cnt <= '0;
      c_r <= 1'b0;
      res <= '0;
      szcv <= '0;
    end else if (state == IDLE && in_valid) begin
      op_r <= op;
      w <= a;
      lo <= b;
      hi <= '0;
      c_r <= 1'b0;
      cnt <= op == OP_MUL ? CNT_MUL : {1'b0, n};
      if (!multi) begin
        res <= r1;
        szcv <= {r1[M], r1 == '0, c1, v1};
      end
    end else if (state == BUSY) begin
      w <= w_n;
      hi <= hi_n;
      lo <= lo_n;
      c_r <= c_n;
      cnt <= cnt - CNT_ONE;
      if (last) begin
        res <= r_b;
        szcv <= {r_b[M], r_b == '0, c_b, 1'b0};
      end
    end
endmodule

// File: doc/alu_seq.md
# alu_seq

Parametrised, multi-cycle successor to the team's 16-bit combinational ALU. It keeps the same opcode map and SZCV flag semantics. It adds a configurable data width, valid/ready handshakes on both sides, iterative one-bit-per-cycle shifts with a correct arithmetic fill, and an iterative shift-add multiply. It sits between the decode/operand-fetch stage and writeback. Because its latency varies with the operation, the pipeline stalls on `in_ready`.

## Interface
- `WIDTH`, 16: datapath width. Must be a power of two, at least 4.
- `SHW`, $clog2(WIDTH): shift-amount width. Derived; do not override.
- `clk`  in  1  single clock. All state updates on the rising edge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `in_valid`  in  1  operation request.
- `in_ready`  out  1  block can accept a request. High only in IDLE.
- `op`  in  4  operation code, sampled at accept.
- `a`  in  WIDTH  operand A, sampled at accept.
- `b`  in  WIDTH  operand B, sampled at accept. Shifts use `b[SHW-1:0]` as the count.
- `out_valid`  out  1  `res`/`szcv` are valid.
- `out_ready`  in  1  consumer accepts the result.
- `res`  out  WIDTH  registered result.
- `szcv`  out  4  registered flags: [3]=S, [2]=Z, [1]=C, [0]=V.

## Operation
- FSM states: IDLE, BUSY, DONE.
  - IDLE: `in_ready`=1. On `in_valid` it latches `op`, `a`, `b`.
  - Single-cycle ops go to DONE with the result computed.
  - A shift with count n>0, or MUL, goes to BUSY.
  - A shift with count 0 goes straight to DONE with `res`=`a` and C=0.
- BUSY:
  - Shifts: one bit per cycle, down-counter from n to 0.
  - MUL: WIDTH iterations of shift-add.
  - When the counter reaches 0, go to DONE.
- DONE: `out_valid`=1. Holds `res`/`szcv` stable until `out_ready`, then goes to IDLE. No new request is accepted in DONE.
- Opcodes. In the arithmetic ops, `{C,res}` is WIDTH+1 bits, unsigned.
  - 0000 ADD: `{C,res}` = a+b.
  - 0001 SUB: `{C,res}` = a-b.
  - 0101 CMP: identical to SUB, `res` included.
  - 0010 AND, 0011 OR, 0100 XOR: C=0.
  - 0110 MOV: `res`=b, C=0.
  - 1000 SLL: fill 0. C = last bit shifted out, a[WIDTH-n].
  - 1001 ROL: rotate left. C=0.
  - 1010 SRL: fill 0. C = a[n-1].
  - 1011 SRA: fill with a[WIDTH-1]. C = a[n-1].
  - 1100 MUL: `res` = low WIDTH bits of unsigned a*b. C=1 iff the high WIDTH bits are nonzero.
  - Any other op: `res`=0, C=0, single-cycle.
- Flags, computed once on entry to DONE:
  - S = `res`[WIDTH-1].
  - Z = (`res`==0).
  - V for ADD: a[MSB]==b[MSB] and res[MSB]!=a[MSB].
  - V for SUB/CMP: a[MSB]!=b[MSB] and res[MSB]!=a[MSB].
  - V=0 for all other ops.
- Internal working registers are never visible on `res` before DONE.

## Timing
- Reset values, with `rst_n` low asynchronously:
  - state=IDLE, `in_ready`=1, `out_valid`=0.
  - `res`=0, `szcv`=0000, counters 0.
- Latency is counted from the accept edge to the edge at which `out_valid` rises.
  - Single-cycle ops and count-0 shifts: 1.
  - Shift by n: n+1.
  - MUL: WIDTH+1.
- Back-to-back throughput:
  - Minimum 2 cycles per op: DONE with `out_ready`=1, then IDLE.
  - `in_ready` goes high the cycle after the result handshake.
- `in_valid` while not `in_ready` is ignored. Operands need not be held after accept.
- `out_ready` high during IDLE or BUSY has no effect.
- Reset asserted mid-BUSY or in DONE aborts the operation. No result is produced. Outputs return to reset values immediately.
- Shift count is taken modulo WIDTH via `b[SHW-1:0]`. Upper bits of `b` are ignored for shifts.

## Test plan
- ADD a=0x7FFF, b=0x0001 (WIDTH=16) -> `res`=0x8000, `szcv`=1001, `out_valid` 1 cycle after accept.
- SUB a=0x0000, b=0x0001 -> `res`=0xFFFF, `szcv`=1010. CMP with the same operands gives the identical result.
- SRA a=0x8004, n=2 -> `res`=0xE001, `szcv`=1000, latency 3. SLL a=0x8001, n=1 -> `res`=0x0002, `szcv`=0010, latency 2.
- MUL a=0x0100, b=0x0100 -> `res`=0x0000, `szcv`=0110, latency 17. MUL 0x0003*0x0005 -> 0x000F, `szcv`=0000.
- Backpressure: hold `out_ready`=0 for 5 cycles in DONE -> `res`/`szcv` stable, `in_ready`=0, a second `in_valid` is ignored. Release -> IDLE next cycle.
- Assert `rst_n`=0 during MUL cycle 8 -> immediate `out_valid`=0, `res`=0, `szcv`=0000, `in_ready`=1. A fresh ADD after release completes normally.
